// File: rtl/uds_ramp_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// uds_ramp_ctrl_pkg
// Shared definitions for the ramp sequencer that drives uds_counter.
//   state_t        : controller state encoding
//   STEP_OVERHEAD  : fixed cycles per ramp step on top of the programmed
//                    interval (CHECK + one WAIT minimum + STEP + SETTLE)
// -----------------------------------------------------------------------------
package uds_ramp_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        WAIT   = 3'd2,
        STEP   = 3'd3,
        JUMP   = 3'd4,
        SETTLE = 3'd5
    } state_t;

    localparam int STEP_OVERHEAD = 4;

endpackage

// File: rtl/uds_counter.sv
// -----------------------------------------------------------------------------
// uds_counter
// Up/down/set saturating counter controlled by uds_ramp_ctrl.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset (counter -> 0)
//   up       in   increment, saturates at MAX
//   down     in   decrement, saturates at 0
//   set      in   load set_val (clamped to MAX); has priority over up/down
//   set_val  in   WIDTH load value
//   out      out  WIDTH current counter value
// -----------------------------------------------------------------------------
module uds_counter #(
    parameter int WIDTH = 8,
    parameter int MAX   = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up,
    input  logic             down,
    input  logic             set,
    input  logic [WIDTH-1:0] set_val,
    output logic [WIDTH-1:0] out
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (set) begin
            r_cnt <= (set_val > MAX_V) ? MAX_V : set_val;
        end else if (up && !down) begin
            if (r_cnt < MAX_V) r_cnt <= r_cnt + WIDTH'(1);
        end else if (down && !up) begin
            if (r_cnt != '0) r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign out = r_cnt;

endmodule

// File: rtl/uds_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// uds_ramp_ctrl
// Sequencer that takes a target over a valid/ready command port and drives a
// uds_counter towards it, either one step per (div + 4) cycles or with a
// single set. Completion is signalled with a one-cycle done pulse.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   cmd_valid    command present
//   cmd_ready    high while idle
//   cmd_target   requested final value (clamped to MAX at acceptance)
//   cmd_jump     1 = single set, 0 = ramp
//   cmd_div      extra idle cycles between ramp steps
//   abort        cancel the active command (ignored while idle)
//   cnt_in       counter value feedback
//   up/down/set  registered counter controls, at most one high
//   set_val      registered counter load value
//   busy         high while not idle
//   done         registered one-cycle completion pulse
// -----------------------------------------------------------------------------
module uds_ramp_ctrl
    import uds_ramp_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX       = 255,
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [WIDTH-1:0]     cmd_target,
    input  logic                 cmd_jump,
    input  logic [DIV_WIDTH-1:0] cmd_div,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     cnt_in,
    output logic                 up,
    output logic                 down,
    output logic                 set,
    output logic [WIDTH-1:0]     set_val,
    output logic                 busy,
    output logic                 done
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_target;
    logic [DIV_WIDTH-1:0] r_div;
    logic [DIV_WIDTH-1:0] r_timer;
    logic                 r_up;
    logic                 r_down;
    logic                 r_set;
    logic                 r_done;
    logic [WIDTH-1:0]     r_set_val;

    logic                 w_accept;
    logic                 w_abort;
    logic                 w_at_target;
    logic                 w_go_up;
    logic [WIDTH-1:0]     w_target_clamped;

    assign w_accept         = cmd_valid && (r_state == IDLE);
    assign w_abort          = abort && (r_state != IDLE);
    assign w_at_target      = (cnt_in == r_target);
    assign w_go_up          = (cnt_in < r_target);
    assign w_target_clamped = (cmd_target > MAX_V) ? MAX_V : cmd_target;

    // Next-state logic; abort overrides every non-idle transition.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_next = cmd_jump ? JUMP : CHECK;
            end
            CHECK:  w_state_next = w_at_target ? IDLE : WAIT;
            WAIT:   w_state_next = (r_timer == '0) ? STEP : WAIT;
            STEP:   w_state_next = SETTLE;
            JUMP:   w_state_next = SETTLE;
            SETTLE: w_state_next = CHECK;
            default: w_state_next = IDLE;
        endcase
        if (w_abort) w_state_next = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Command latch and interval timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_target <= '0;
            r_div    <= '0;
            r_timer  <= '0;
        end else begin
            if (w_accept) begin
                r_target <= w_target_clamped;
                r_div    <= cmd_div;
            end
            if (r_state == CHECK) begin
                r_timer <= r_div;
            end else if ((r_state == WAIT) && (r_timer != '0)) begin
                r_timer <= r_timer - DIV_WIDTH'(1);
            end
        end
    end

    // Controls are decoded from the next state so each pulse lines up exactly
    // with the STEP/JUMP cycle. Direction is re-read from cnt_in on every step.
    // The jump value comes straight from the command port because r_target is
    // only loaded on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_up      <= 1'b0;
            r_down    <= 1'b0;
            r_set     <= 1'b0;
            r_done    <= 1'b0;
            r_set_val <= '0;
        end else begin
            r_up   <= (w_state_next == STEP) && w_go_up;
            r_down <= (w_state_next == STEP) && !w_go_up;
            r_set  <= (w_state_next == JUMP);
            r_done <= (r_state == CHECK) && w_at_target && !abort;
            if (w_accept && cmd_jump) r_set_val <= w_target_clamped;
        end
    end

    assign cmd_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign up        = r_up;
    assign down      = r_down;
    assign set       = r_set;
    assign set_val   = r_set_val;
    assign done      = r_done;

endmodule

// File: tb/tb_uds_ramp_ctrl.sv
module tb_uds_ramp_ctrl;
    import uds_ramp_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    // instance 1: MAX = 255
    logic       cmd_valid, cmd_jump, abort;
    logic [7:0] cmd_target, cmd_div;
    logic       cmd_ready, up, down, set, busy, done;
    logic [7:0] set_val, cnt;
    // instance 2: MAX = 200
    logic       c2_valid, c2_jump, c2_abort;
    logic [7:0] c2_target, c2_div;
    logic       c2_ready, c2_up, c2_down, c2_set, c2_busy, c2_done;
    logic [7:0] c2_set_val, c2_cnt;

    always #5 clk = ~clk;

    uds_ramp_ctrl #(.WIDTH(8), .MAX(255), .DIV_WIDTH(8)) u_ctrl (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_target(cmd_target), .cmd_jump(cmd_jump), .cmd_div(cmd_div),
        .abort(abort), .cnt_in(cnt), .up(up), .down(down), .set(set),
        .set_val(set_val), .busy(busy), .done(done)
    );
    uds_counter #(.WIDTH(8), .MAX(255)) u_cnt (
        .clk(clk), .rst(rst), .up(up), .down(down), .set(set),
        .set_val(set_val), .out(cnt)
    );

    uds_ramp_ctrl #(.WIDTH(8), .MAX(200), .DIV_WIDTH(8)) u_ctrl2 (
        .clk(clk), .rst(rst), .cmd_valid(c2_valid), .cmd_ready(c2_ready),
        .cmd_target(c2_target), .cmd_jump(c2_jump), .cmd_div(c2_div),
        .abort(c2_abort), .cnt_in(c2_cnt), .up(c2_up), .down(c2_down), .set(c2_set),
        .set_val(c2_set_val), .busy(c2_busy), .done(c2_done)
    );
    uds_counter #(.WIDTH(8), .MAX(200)) u_cnt2 (
        .clk(clk), .rst(rst), .up(c2_up), .down(c2_down), .set(c2_set),
        .set_val(c2_set_val), .out(c2_cnt)
    );

    int n_total = 0;
    int n_pass  = 0;

    // per-transaction traces, bit k = value sampled in cycle T+k
    logic [63:0] tr_up, tr_down, tr_set, tr_done, tr_busy;
    logic [7:0]  tr_sv1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Issue a command (valid driven now, accepted on the next rising edge =
    // end of cycle T), then sample ncyc cycles. abort is raised in cycle
    // T+abort_at (0 = never) for one cycle.
    task automatic run(input int sel, input logic [7:0] tgt, input logic jmp,
                       input logic [7:0] dv, input int ncyc, input int abort_at);
        tr_up = '0; tr_down = '0; tr_set = '0; tr_done = '0; tr_busy = '0; tr_sv1 = '0;
        if (sel == 2) begin
            c2_valid = 1'b1; c2_target = tgt; c2_jump = jmp; c2_div = dv;
        end else begin
            cmd_valid = 1'b1; cmd_target = tgt; cmd_jump = jmp; cmd_div = dv;
        end
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (k == 1) begin
                cmd_valid = 1'b0;
                c2_valid  = 1'b0;
                tr_sv1    = (sel == 2) ? c2_set_val : set_val;
            end
            if (sel == 2) begin
                tr_up[k] = c2_up; tr_down[k] = c2_down; tr_set[k] = c2_set;
                tr_done[k] = c2_done; tr_busy[k] = c2_busy;
            end else begin
                tr_up[k] = up; tr_down[k] = down; tr_set[k] = set;
                tr_done[k] = done; tr_busy[k] = busy;
            end
            abort = (k == abort_at);
        end
        abort = 1'b0;
        $display("txn sel=%0d tgt=%0d jump=%0d div=%0d up=%0h down=%0h set=%0h done=%0h cnt=%0d",
                 sel, tgt, jmp, dv, tr_up, tr_down, tr_set, tr_done, (sel == 2) ? c2_cnt : cnt);
    endtask

    function automatic logic [63:0] bit_at(input int k);
        logic [63:0] one;
        one = 64'd1;
        return one << k;
    endfunction

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b1; cmd_target = 8'd5; cmd_jump = 1'b1; cmd_div = 8'd0; abort = 1'b0;
        c2_valid = 1'b0; c2_target = 8'd0; c2_jump = 1'b0; c2_div = 8'd0; c2_abort = 1'b0;
        repeat (3) @(negedge clk);

        // Reset with cmd_valid held high
        chk("rst_outputs", {59'd0, up, down, set, done, busy}, 64'd0);
        chk("rst_set_val", {56'd0, set_val}, 64'd0);
        chk("rst_ready", {63'd0, cmd_ready}, 64'd1);
        rst = 1'b0;

        // First command (jump to 5) accepted on the first edge after release
        run(1, 8'd5, 1'b1, 8'd0, 6, 0);
        chk("first_set", tr_set, bit_at(1));
        chk("first_done", tr_done, bit_at(4));
        chk("first_cnt", {56'd0, cnt}, 64'd5);

        // Ramp 5 -> 8, div 0: up at T+3,7,11, done at T+2+3*4
        run(1, 8'd8, 1'b0, 8'd0, 18, 0);
        chk("r58_up", tr_up, bit_at(3) | bit_at(7) | bit_at(11));
        chk("r58_done", tr_done, bit_at(2 + 3 * (0 + STEP_OVERHEAD)));
        chk("r58_downset", tr_down | tr_set, 64'd0);
        chk("r58_cnt", {56'd0, cnt}, 64'd8);

        // Ramp 10 -> 8, div 2: down at T+5,11, done T+14, busy T+1..T+13
        run(1, 8'd10, 1'b1, 8'd0, 6, 0);
        chk("pre10_cnt", {56'd0, cnt}, 64'd10);
        run(1, 8'd8, 1'b0, 8'd2, 18, 0);
        chk("r108_down", tr_down, bit_at(5) | bit_at(11));
        chk("r108_done", tr_done, bit_at(14));
        chk("r108_busy", tr_busy, 64'h3FFE);
        chk("r108_upset", tr_up | tr_set, 64'd0);
        chk("r108_cnt", {56'd0, cnt}, 64'd8);

        // Jump 3 -> 200: set/set_val at T+1 only, done T+4
        run(1, 8'd3, 1'b1, 8'd0, 6, 0);
        run(1, 8'd200, 1'b1, 8'd0, 8, 0);
        chk("j200_set", tr_set, bit_at(1));
        chk("j200_setval", {56'd0, tr_sv1}, 64'd200);
        chk("j200_done", tr_done, bit_at(4));
        chk("j200_updown", tr_up | tr_down, 64'd0);
        chk("j200_cnt", {56'd0, cnt}, 64'd200);

        // Already at target: no pulses, done at T+2
        run(1, 8'd7, 1'b1, 8'd0, 6, 0);
        run(1, 8'd7, 1'b0, 8'd3, 6, 0);
        chk("eq_pulses", tr_up | tr_down | tr_set, 64'd0);
        chk("eq_done", tr_done, bit_at(2));
        chk("eq_busy", tr_busy, bit_at(1));

        // Abort: ramp 0 -> 50, div 1, abort in third WAIT (T+12)
        run(1, 8'd0, 1'b1, 8'd0, 6, 0);
        run(1, 8'd50, 1'b0, 8'd1, 20, 12);
        chk("ab_up", tr_up, bit_at(4) | bit_at(9));
        chk("ab_done", tr_done, 64'd0);
        chk("ab_busy", tr_busy, 64'h1FFE);
        chk("ab_cnt", {56'd0, cnt}, 64'd2);
        chk("ab_ready", {63'd0, cmd_ready}, 64'd1);
        run(1, 8'd9, 1'b1, 8'd0, 6, 0);
        chk("ab_next_done", tr_done, bit_at(4));
        chk("ab_next_cnt", {56'd0, cnt}, 64'd9);

        // MAX = 200: jump to 198, then ramp to 255 clamps and ends at 200
        run(2, 8'd198, 1'b1, 8'd0, 6, 0);
        run(2, 8'd255, 1'b0, 8'd0, 14, 0);
        chk("clamp_up", tr_up, bit_at(3) | bit_at(7));
        chk("clamp_done", tr_done, bit_at(2 + 2 * STEP_OVERHEAD));
        chk("clamp_cnt", {56'd0, c2_cnt}, 64'd200);
        chk("clamp_ready", {63'd0, c2_ready}, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uds_ramp_ctrl.md
Name: uds_ramp_ctrl

Overview:
- Sequencer for the team's up/down/set saturating counter (uds_counter).
- Accepts a target value over a valid/ready command interface, then drives the counter's up/down/set controls.
- Either ramps the counter one step at a time at a programmable interval, or jumps it directly to the target.
- Observes the counter value through a feedback port, signals completion with a done pulse, and supports abort.

Parameters:
- WIDTH, 8, width of the counter value, target and set value.
- MAX, 255, counter ceiling; must equal the MAX of the controlled counter.
- DIV_WIDTH, 8, width of the step-interval field.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  high iff state==IDLE.
- cmd_target  input  WIDTH  requested final counter value.
- cmd_jump  input  1  1 = single set to target; 0 = ramp.
- cmd_div  input  DIV_WIDTH  extra idle cycles between ramp steps.
- abort  input  1  cancels the active command.
- cnt_in  input  WIDTH  current counter value (counter's out).
- up  output  1  counter up control, registered.
- down  output  1  counter down control, registered.
- set  output  1  counter set control, registered.
- set_val  output  WIDTH  counter load value, registered.
- busy  output  1  high iff state!=IDLE.
- done  output  1  one-cycle completion pulse, registered.

Behaviour:
- Reset, asynchronous: state=IDLE; up, down, set, done = 0; set_val = 0; timer = 0; target = 0. cmd_ready=1 and busy=0 follow from IDLE.
- States are IDLE, CHECK, WAIT, STEP, JUMP, SETTLE.
- Registered outputs: at most one of up/down/set is high in any cycle. up/down are high exactly in STEP cycles; set is high exactly in JUMP cycles.
- IDLE:
  - Accept when cmd_valid && cmd_ready.
  - Latch target = min(cmd_target, MAX) and div = cmd_div.
  - cmd_jump=1 -> JUMP; otherwise -> CHECK.
- JUMP: set=1 and set_val=target for one cycle -> SETTLE.
- CHECK:
  - cnt_in == target -> IDLE with done=1 in the first IDLE cycle.
  - Otherwise timer = div -> WAIT.
- WAIT: timer==0 -> STEP; otherwise timer decrements. WAIT lasts div+1 cycles.
- STEP:
  - up=1 if cnt_in < target, otherwise down=1.
  - Direction is re-evaluated on every step, so external disturbance of the counter converges.
  - -> SETTLE.
- SETTLE: one cycle so the counter update becomes visible on cnt_in -> CHECK.
- Ramp step period = div+4 cycles.
- Latency from acceptance at cycle T to done:
  - already equal: done at T+2;
  - jump: done at T+4;
  - ramp of n steps: done at T+2+n*(div+4).
- Clamp: a target above MAX is clamped to MAX at acceptance. The ramp therefore always terminates, because the counter saturates at MAX and 0.
- Abort:
  - Sampled in any non-IDLE state -> IDLE next cycle.
  - No done pulse; up/down/set are 0 from the next cycle.
  - A pulse already being driven in the abort cycle still takes effect.
  - Abort in IDLE is ignored; a simultaneous cmd_valid in IDLE is accepted.
- cmd_* inputs are ignored while busy; the latched command is unaffected.
- Reset mid-operation: immediate return to reset values; any in-flight pulse is dropped asynchronously.

Decomposition:
- Shared package holds:
  - state encoding enum: IDLE, CHECK, WAIT, STEP, JUMP, SETTLE;
  - localparam for the fixed step overhead (4 cycles).
- No sub-module inside the controller. The uds_counter instance lives in the parent.
- The bench instantiates uds_ramp_ctrl plus uds_counter (WIDTH=8, MAX=255), with cnt_in tied to the counter's out.

Test Plan:
- Reset with cmd_valid=1 held -> all outputs 0, cmd_ready=1 after release; first command is accepted on the first post-reset edge.
- Counter=5; ramp to target 8, div=0, accepted at T -> up pulses at T+3, T+7, T+11; counter=8; done at T+14 only; no down/set.
- Counter=10; ramp to target 8, div=2 -> down pulses exactly 6 cycles apart; done at T+14; busy high T+1..T+13.
- Counter=3; jump to target 200 -> set=1 with set_val=200 at T+1 only; done at T+4; counter=200.
- Counter=7; ramp to target 7 -> no pulses; done at T+2. Separately, target=255 with MAX=200 -> ramp ends at 200 with done.
- Ramp 0->50, div=1; abort asserted during the third WAIT -> IDLE next cycle, no done, counter stays 2, cmd_ready=1; a new command is then accepted normally.
